// File: rtl/vga_frame_capture.sv
// ---------------------------------------------------------------------------
// vga_frame_capture
// Receive side of the 640x480 VGA timing. Samples an incoming hsync/vsync/RGB
// stream in the clk domain and writes a W x H window of pixels, packed to
// 8 bits, into the write port of the frame-buffer bram. One frame is captured
// per start request.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high
//   start       1-cycle request to capture the next full frame
//   hsync_in    active-low line sync
//   vsync_in    active-low frame sync
//   red_in      pixel red   (4 bits)
//   green_in    pixel green (4 bits)
//   blue_in     pixel blue  (4 bits)
//   wr_en       bram write strobe, one clk per captured pixel
//   wr_addr     bram write address (raster order from 0)
//   wr_data     packed pixel {blue[1:0], green[2:0], red[2:0]}
//   busy        high while waiting for vsync or capturing
//   frame_done  1-clk pulse, coincident with the last pixel write
//   frame_err   sticky: frame ended before W*H pixels were written
//   line_err    sticky: a line length differed from HPIXELS*CLK_DIV clk
// ---------------------------------------------------------------------------
module vga_frame_capture #(
  parameter int CLK_DIV   = 4,
  parameter int HPIXELS   = 800,
  parameter int HBP       = 144,
  parameter int VBP       = 31,
  parameter int X0        = 100,
  parameter int Y0        = 100,
  parameter int W         = 256,
  parameter int H         = 256,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [3:0]           red_in,
  input  logic [3:0]           green_in,
  input  logic [3:0]           blue_in,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 line_err
);

  localparam int DIV_BITS = $clog2(CLK_DIV);
  // One spare bit so an over-long line saturates instead of aliasing a
  // legal length.
  localparam int HCW = $clog2(HPIXELS * CLK_DIV) + 1;
  localparam int VCW = $clog2(VBP + Y0 + H) + 2;

  localparam logic [HCW-1:0]       LINE_CLKS    = HCW'(HPIXELS * CLK_DIV);
  localparam logic [HCW-1:0]       COL_LO       = HCW'(HBP + X0);
  localparam logic [HCW-1:0]       COL_HI       = HCW'(HBP + X0 + W);
  localparam logic [VCW-1:0]       ROW_LO       = VCW'(VBP + Y0);
  localparam logic [VCW-1:0]       ROW_HI       = VCW'(VBP + Y0 + H);
  localparam logic [DIV_BITS-1:0]  SAMPLE_PHASE = DIV_BITS'(CLK_DIV / 2);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR    = ADDR_BITS'(W * H - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t state, state_next;

  // Input stage (S1) and the previous sync values for edge detection.
  logic       hsync_s1, vsync_s1, hsync_prev, vsync_prev;
  logic [7:0] pix_s1;

  logic [HCW-1:0]       hcc;
  logic [HCW-1:0]       hc;
  logic [VCW-1:0]       vc;
  logic [ADDR_BITS-1:0] pix_cnt;
  logic                 first_line;

  logic hs_fall, vs_fall, sample, in_window, do_write;

  // The dropped colour bits are intentionally discarded by the packing.
  logic unused_pins;
  assign unused_pins = &{red_in[3], green_in[3], blue_in[3:2]};

  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update together from pre-edge values; blocking here would
  // make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_s1   <= 1'b1;
      vsync_s1   <= 1'b1;
      hsync_prev <= 1'b1;
      vsync_prev <= 1'b1;
      pix_s1     <= '0;
    end else begin
      hsync_s1   <= hsync_in;
      vsync_s1   <= vsync_in;
      hsync_prev <= hsync_s1;
      vsync_prev <= vsync_s1;
      // Only the bits that survive packing are stored.
      pix_s1     <= {blue_in[1:0], green_in[2:0], red_in[2:0]};
    end
  end

  assign hs_fall   = hsync_prev & ~hsync_s1;
  assign vs_fall   = vsync_prev & ~vsync_s1;
  assign hc        = hcc >> DIV_BITS;
  assign sample    = (hcc[DIV_BITS-1:0] == SAMPLE_PHASE);
  assign in_window = (hc >= COL_LO) && (hc < COL_HI) &&
                     (vc >= ROW_LO) && (vc < ROW_HI);
  // A vsync edge in CAPTURE aborts the frame, so it also suppresses a write.
  assign do_write  = (state == CAPTURE) && !vs_fall && sample && in_window;

  // Position counters run regardless of FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcc <= '0;
      vc  <= '0;
    end else begin
      if (hs_fall)        hcc <= '0;
      else if (hcc != '1) hcc <= hcc + 1'b1;

      if (vs_fall)                   vc <= '0;
      else if (hs_fall && vc != '1)  vc <= vc + 1'b1;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM: next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = WAIT_VS;
      WAIT_VS: if (vs_fall) state_next = CAPTURE;
      CAPTURE: begin
        if (vs_fall)                              state_next = IDLE;
        else if (do_write && pix_cnt == LAST_ADDR) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs decoded from state.
  always_comb begin
    busy       = (state == WAIT_VS) || (state == CAPTURE);
    frame_done = (state == DONE);
  end

  // Write port, pixel counter and error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      pix_cnt    <= '0;
      frame_err  <= 1'b0;
      line_err   <= 1'b0;
      first_line <= 1'b0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= pix_cnt;
        wr_data <= pix_s1;
        pix_cnt <= pix_cnt + 1'b1;
      end

      if (state == IDLE && start) begin
        frame_err <= 1'b0;
        line_err  <= 1'b0;
        pix_cnt   <= '0;
      end

      if (state == CAPTURE && vs_fall) frame_err <= 1'b1;

      // The first hsync edge in CAPTURE closes a line that began before
      // capture was armed, so its length is not judged.
      if (state == WAIT_VS && vs_fall)      first_line <= 1'b1;
      else if (state == CAPTURE && hs_fall) first_line <= 1'b0;

      if (state == CAPTURE && hs_fall && !first_line &&
          (hcc + 1'b1) != LINE_CLKS)
        line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_capture
// Directed bench for vga_frame_capture on a scaled-down timing:
// 4 clk/pixel, 16 pixels/line, 10 lines/frame, 4x4 window at columns 4..7,
// rows 3..6, 4-bit addresses (W*H == 2**ADDR_BITS).
// ---------------------------------------------------------------------------
module tb_vga_frame_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       hsync_in, vsync_in;
  logic [3:0] red_in, green_in, blue_in;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, frame_done, frame_err, line_err;

  vga_frame_capture #(
    .CLK_DIV  (4),
    .HPIXELS  (16),
    .HBP      (3),
    .VBP      (2),
    .X0       (1),
    .Y0       (1),
    .W        (4),
    .H        (4),
    .ADDR_BITS(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .red_in    (red_in),
    .green_in  (green_in),
    .blue_in   (blue_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .line_err  (line_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  int exp_n     = 0;   // writes observed in the current test
  int exp_limit = 0;   // writes the current test allows
  int done_cnt  = 0;
  int done_at   = -1;
  bit special_on = 1'b0;
  int spec_cyc   = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus colour for pixel column x of line y, as {blue, green, red}.
  function automatic logic [11:0] pix_rgb(input int x, input int y);
    logic [3:0] r, g, b;
    r = 4'(x * 3 + y);
    g = 4'(y * 5 + x + 1);
    b = 4'(x + 2 * y);
    return {b, g, r};
  endfunction

  function automatic logic [7:0] pack(input logic [11:0] bgr);
    return {bgr[9:8], bgr[6:4], bgr[2:0]};
  endfunction

  // Write n lands at window column n%4, row n/4 -> line x=4+n%4, y=3+n/4.
  function automatic logic [7:0] exp_data(input int n);
    int k;
    k = n % 16;
    if (special_on && k == 5) return 8'h8F;
    return pack(pix_rgb(4 + k % 4, 3 + k / 4));
  endfunction

  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_n < exp_limit) begin
        check("wr_addr", wr_addr, 32'(exp_n % 16));
        check("wr_data", wr_data, exp_data(exp_n));
      end else begin
        check("stray_wr_en", wr_en, 1'b0);
      end
      exp_n++;
    end
    if (frame_done) begin
      done_cnt++;
      done_at = exp_n;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      start    = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Frame of nlines lines; line short_line is 15 pixels long; start is pulsed
  // at (st_line, st_p); the special pixel goes out on line 4 at clk 23.
  task automatic drive_frame(input int nlines, input int short_line,
                             input int st_line, input int st_p,
                             input bit special);
    int len;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == short_line) ? 60 : 64;
      for (int p = 0; p < len; p++) begin
        @(posedge clk); #1;
        hsync_in = (p < 8) ? 1'b0 : 1'b1;
        vsync_in = (ln == 0) ? 1'b0 : 1'b1;
        start    = (ln == st_line && p == st_p);
        if (special && ln == 4 && p == 23) begin
          {blue_in, green_in, red_in} = {4'h6, 4'h9, 4'hF};
          spec_cyc = cyc;
        end else begin
          {blue_in, green_in, red_in} = pix_rgb(p / 4, ln);
        end
      end
    end
  endtask

  task automatic new_test(input int limit);
    exp_n     = 0;
    exp_limit = limit;
    done_cnt  = 0;
    done_at   = -1;
  endtask

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    red_in = '0; green_in = '0; blue_in = '0;

    // Reset state.
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_line_err", line_err, 0);
    reset = 1'b0;
    idle(20);

    // Clean frame, including the F/9/6 pixel and its two-clock latency.
    new_test(16);
    special_on = 1'b1;
    pulse_start();
    @(negedge clk);
    check("armed_busy", busy, 1);
    fork
      drive_frame(10, -1, -1, -1, 1'b1);
      begin
        while (spec_cyc < 0) @(posedge clk);
        wait (cyc == spec_cyc + 2);
        @(negedge clk);
        check("lat_wr_en", wr_en, 1);
        check("lat_wr_data", wr_data, 8'h8F);
      end
    join
    idle(5);
    special_on = 1'b0;
    check("clean_writes", exp_n, 16);
    check("clean_done_cnt", done_cnt, 1);
    check("clean_done_at", done_at, 16);
    check("clean_frame_err", frame_err, 0);
    check("clean_line_err", line_err, 0);
    check("clean_busy", busy, 0);

    // vsync drops after line 4: capture aborts with 8 pixels written.
    new_test(8);
    pulse_start();
    drive_frame(5, -1, -1, -1, 1'b0);
    drive_frame(10, -1, -1, -1, 1'b0);
    idle(5);
    check("abort_frame_err", frame_err, 1);
    check("abort_busy", busy, 0);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_writes", exp_n, 8);
    check("abort_line_err", line_err, 0);

    // Short line 1 plus a start request mid-capture.
    new_test(16);
    pulse_start();
    @(negedge clk);
    check("start_clears_frame_err", frame_err, 0);
    drive_frame(10, 1, 4, 10, 1'b0);
    idle(5);
    check("short_line_err", line_err, 1);
    check("short_done_cnt", done_cnt, 1);
    check("short_writes", exp_n, 16);
    check("short_frame_err", frame_err, 0);

    // start coincides with the vsync edge: waits a full frame.
    new_test(16);
    drive_frame(10, -1, 0, 1, 1'b0);
    check("edge_start_busy", busy, 1);
    check("edge_start_writes", exp_n, 0);
    drive_frame(10, -1, -1, -1, 1'b0);
    idle(5);
    check("edge_start_writes2", exp_n, 16);
    check("edge_start_done_cnt", done_cnt, 1);
    check("edge_start_line_err", line_err, 0);

    // Reset after the sixth pixel write.
    new_test(6);
    pulse_start();
    fork
      drive_frame(10, -1, -1, -1, 1'b0);
      begin
        int waited;
        waited = 0;
        while (exp_n < 6 && waited < 3000) begin
          @(posedge clk);
          waited++;
        end
        if (exp_n < 6) begin
          check("reset_trigger", exp_n, 6);
        end else begin
          #1 reset = 1'b1;
          @(posedge clk);
          @(negedge clk);
          check("mid_rst_wr_en", wr_en, 0);
          check("mid_rst_wr_addr", wr_addr, 0);
          check("mid_rst_wr_data", wr_data, 0);
          check("mid_rst_busy", busy, 0);
          check("mid_rst_frame_done", frame_done, 0);
          check("mid_rst_frame_err", frame_err, 0);
          check("mid_rst_line_err", line_err, 0);
          reset = 1'b0;
        end
      end
    join
    idle(5);
    check("mid_rst_writes", exp_n, 6);
    check("mid_rst_done_cnt", done_cnt, 0);

    // Fresh start after the reset recaptures from address 0.
    new_test(16);
    pulse_start();
    drive_frame(10, -1, -1, -1, 1'b0);
    idle(5);
    check("recap_writes", exp_n, 16);
    check("recap_done_cnt", done_cnt, 1);
    check("recap_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
